// File: rtl/pcie_tx_source.sv
// pcie_tx_source
//   Transmit-side feeder for the PCIe transaction block. Host words are
//   buffered in a small FIFO. They are forwarded one per cycle on
//   data_in_principal/push while the transaction block is active and is
//   not applying back-pressure.
//
//   Optional feature: define TX_PAUSE_CNT_EN to add the pause_cycles
//   output. It counts cycles spent in PAUSE while the FIFO is non-empty
//   and saturates at 16'hFFFF. Only reset clears it.
//
// Ports:
//   clk               single clock, rising edge
//   reset_L           asynchronous active-low reset
//   init              enable; low stops pushing but keeps FIFO contents
//   active_in         transaction block active_out; pushing only while high
//   Pausa_MF          back-pressure from the transaction block main FIFO
//   wr_en/wr_data     host write strobe and word
//   wr_full           FIFO full (combinational from occupancy)
//   wr_err            one-cycle pulse when a write hits a full FIFO
//   data_in_principal registered word to the transaction block
//   push              registered push strobe to the transaction block
//   fifo_count        occupancy, 0..DEPTH
//   tx_count          words pushed, wraps modulo 256
//   state_out         FSM state (IDLE=00, SEND=01, PAUSE=10)
//
// Handshake: push is a valid-only strobe with no ready return. Each cycle
// with push=1 transfers exactly one word on data_in_principal. Flow control
// comes only from Pausa_MF. A Pausa_MF rise at edge k stops push from
// cycle k+1. The word already launched at edge k is absorbed by the
// downstream threshold.

module pcie_tx_source #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              active_in,
  input  logic              Pausa_MF,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wr_err,
  output logic [DATA_W-1:0] data_in_principal,
  output logic              push,
  output logic [ADDR_W:0]   fifo_count,
  output logic [7:0]        tx_count,
  output logic [1:0]        state_out
`ifdef TX_PAUSE_CNT_EN
  ,
  output logic [15:0]       pause_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND  = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_push;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_tx_count;
  logic                r_wr_err;

  logic w_run;
  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_pop;

  // init and active_in both high: the link may carry traffic at all.
  assign w_run    = init & active_in;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  // The write decision uses pre-edge occupancy. A pop at the same edge
  // does not make room for a write into a full FIFO.
  assign w_wr_acc = wr_en & ~w_full;
  assign w_pop    = (r_state == SEND) & ~Pausa_MF & w_run & ~w_empty;

  // FIFO storage. No reset is needed because fifo_count alone decides
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy. A simultaneous write and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en & w_full;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_wr_acc && !w_pop) begin
        r_count <= r_count + (ADDR_W+1)'(1);
      end else if (!w_wr_acc && w_pop) begin
        r_count <= r_count - (ADDR_W+1)'(1);
      end
    end
  end

  // Control FSM with registered push, data and transmit counter.
  // Dropping init or active_in overrides every other transition.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= IDLE;
      r_push     <= 1'b0;
      r_data     <= '0;
      r_tx_count <= '0;
    end else begin
      if (!w_run) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE:    r_state <= SEND;
          SEND:    r_state <= Pausa_MF ? PAUSE : SEND;
          PAUSE:   r_state <= Pausa_MF ? PAUSE : SEND;
          default: r_state <= IDLE;
        endcase
      end

      r_push <= w_pop;
      if (w_pop) begin
        r_data     <= r_mem[r_rd_ptr];
        r_tx_count <= r_tx_count + 8'd1;
      end
    end
  end

`ifdef TX_PAUSE_CNT_EN
  logic [15:0] r_pause_cycles;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_pause_cycles <= '0;
    end else if ((r_state == PAUSE) && !w_empty && (r_pause_cycles != 16'hFFFF)) begin
      r_pause_cycles <= r_pause_cycles + 16'd1;
    end
  end

  assign pause_cycles = r_pause_cycles;
`endif

  assign wr_full           = w_full;
  assign wr_err            = r_wr_err;
  assign data_in_principal = r_data;
  assign push              = r_push;
  assign fifo_count        = r_count;
  assign tx_count          = r_tx_count;
  assign state_out         = r_state;

endmodule

// File: tb/tb_pcie_tx_source.sv
// Self-checking bench for pcie_tx_source. A queue-based reference model
// predicts every output after each clock edge. Directed scenarios add
// literal checks on top of the model.

module tb_pcie_tx_source;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_L;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic              init, active_in, Pausa_MF, wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full, wr_err, push;
  logic [DATA_W-1:0] data_in_principal;
  logic [ADDR_W:0]   fifo_count;
  logic [7:0]        tx_count;
  logic [1:0]        state_out;
`ifdef TX_PAUSE_CNT_EN
  logic [15:0]       pause_cycles;
`endif

  pcie_tx_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .reset_L           (reset_L),
    .init              (init),
    .active_in         (active_in),
    .Pausa_MF          (Pausa_MF),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .wr_full           (wr_full),
    .wr_err            (wr_err),
    .data_in_principal (data_in_principal),
    .push              (push),
    .fifo_count        (fifo_count),
    .tx_count          (tx_count),
    .state_out         (state_out)
`ifdef TX_PAUSE_CNT_EN
    ,
    .pause_cycles      (pause_cycles)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int total;
  int bad;

  logic [DATA_W-1:0] exp_q[$];   // words the model holds in the FIFO
  logic [DATA_W-1:0] got_q[$];   // words observed on the push interface
  int                m_mode;     // 0 idle, 1 send, 2 pause
  logic              m_push;
  logic [DATA_W-1:0] m_data;
  int                m_tx;
  logic              m_err;
  int                m_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_mode = 0;
    m_push = 1'b0;
    m_data = '0;
    m_tx   = 0;
    m_err  = 1'b0;
    m_pc   = 0;
  endtask

  // Advance the model by one edge using the inputs that are currently applied.
  task automatic model_step();
    bit run, pop, acc;
    int sz;
    sz  = exp_q.size();
    run = init && active_in;
    pop = (m_mode == 1) && !Pausa_MF && run && (sz > 0);
    acc = wr_en && (sz < DEPTH);
    m_err = wr_en && !acc;
    if (m_mode == 2 && sz > 0 && m_pc < 65535) m_pc++;
    if (pop) begin
      m_push = 1'b1;
      m_data = exp_q.pop_front();
      m_tx   = (m_tx + 1) % 256;
    end else begin
      m_push = 1'b0;
    end
    if (acc) exp_q.push_back(wr_data);
    if (!run)           m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else                m_mode = Pausa_MF ? 2 : 1;
  endtask

  task automatic compare_all();
    chk("push",       32'(push),              32'(m_push));
    chk("data",       32'(data_in_principal), 32'(m_data));
    chk("wr_err",     32'(wr_err),            32'(m_err));
    chk("fifo_count", 32'(fifo_count),        32'(exp_q.size()));
    chk("wr_full",    32'(wr_full),           32'(exp_q.size() == DEPTH));
    chk("tx_count",   32'(tx_count),          32'(m_tx));
    chk("state_out",  32'(state_out),         32'(m_mode));
`ifdef TX_PAUSE_CNT_EN
    chk("pause_cycles", 32'(pause_cycles),    32'(m_pc));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock: predict, take the edge, sample 1ns later and compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (push) got_q.push_back(data_in_principal);
  endtask

  task automatic idle_inputs();
    init = 0; active_in = 0; Pausa_MF = 0; wr_en = 0; wr_data = '0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    idle_inputs();
    model_clear();
    got_q.delete();
    @(posedge clk);
    #1;
    chk("rst_push",  32'(push),       32'd0);
    chk("rst_tx",    32'(tx_count),   32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_state", 32'(state_out),  32'd0);
    chk("rst_data",  32'(data_in_principal), 32'd0);
    reset_L = 1'b1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    wr_en = 1; wr_data = w;
    cycle();
    wr_en = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] words [6];

  initial begin
    total = 0;
    bad   = 0;
    reset_L = 1'b0;
    idle_inputs();
    model_clear();
    #2;

    // Test 1: single word goes through one cycle after its write.
    do_reset();
    init = 1; active_in = 1;
    cycle();
    chk("t1_state_send", 32'(state_out), 32'd1);
    write_word(6'h15);
    chk("t1_no_bypass", 32'(push), 32'd0);
    cycle();
    chk("t1_push", 32'(push), 32'd1);
    chk("t1_data", 32'(data_in_principal), 32'h15);
    chk("t1_tx",   32'(tx_count), 32'd1);

    // Test 2: fill under back-pressure, overflow write, then drain.
    do_reset();
    init = 1; active_in = 1; Pausa_MF = 1;
    cycle();
    for (int i = 0; i < DEPTH; i++) write_word(6'($urandom_range(0, 63)));
    chk("t2_count8", 32'(fifo_count), 32'd8);
    chk("t2_full",   32'(wr_full),    32'd1);
    chk("t2_nopush", 32'(push),       32'd0);
    write_word(6'h3F);
    chk("t2_err",    32'(wr_err),     32'd1);
    chk("t2_still8", 32'(fifo_count), 32'd8);
    cycle();
    chk("t2_err_one", 32'(wr_err),    32'd0);
    Pausa_MF = 0;
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_drained", 32'(fifo_count), 32'd0);
    chk("t2_tx8",     32'(tx_count),   32'd8);

    // Test 3: 3-cycle pause mid-stream keeps order.
    do_reset();
    init = 1; active_in = 1; Pausa_MF = 1;
    cycle();
    for (int i = 1; i <= 5; i++) write_word(6'(i));
    Pausa_MF = 0;
    cycle();
    cycle();
    cycle();
    Pausa_MF = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_paused", 32'(push), 32'd0);
    end
    Pausa_MF = 0;
    for (int i = 0; i < 6; i++) cycle();
    chk("t3_n", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("t3_order", 32'(got_q[i]), 32'(i + 1));
    chk("t3_tx", 32'(tx_count), 32'd5);

    // Test 4: drop active_in with 4 words left, then resume.
    do_reset();
    init = 1; active_in = 1; Pausa_MF = 1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      words[i] = 6'($urandom_range(0, 63));
      write_word(words[i]);
    end
    Pausa_MF = 0;
    cycle();
    cycle();
    cycle();
    chk("t4_left4", 32'(fifo_count), 32'd4);
    active_in = 0;
    cycle();
    chk("t4_idle",   32'(state_out), 32'd0);
    chk("t4_nopush", 32'(push),      32'd0);
    cycle();
    active_in = 1;
    for (int i = 0; i < 7; i++) cycle();
    chk("t4_n", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) chk("t4_order", 32'(got_q[i]), 32'(words[i]));

    // Test 5: 256 words streamed with continuous writes; tx_count wraps.
    do_reset();
    init = 1; active_in = 1;
    cycle();
    wr_en = 1;
    for (int i = 0; i < 256; i++) begin
      wr_data = 6'($urandom_range(0, 63));
      cycle();
      chk("t5_count1", 32'(fifo_count), 32'd1);
    end
    wr_en = 0;
    cycle();
    chk("t5_push_last", 32'(push),     32'd1);
    chk("t5_tx_wrap",   32'(tx_count), 32'd0);

    // Test 6: asynchronous reset mid-burst.
    do_reset();
    init = 1; active_in = 1;
    cycle();
    wr_en = 1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 6'($urandom_range(0, 63));
      cycle();
    end
    #2;
    reset_L = 1'b0;
    #1;
    chk("t6_push", 32'(push),       32'd0);
    chk("t6_tx",   32'(tx_count),   32'd0);
    chk("t6_cnt",  32'(fifo_count), 32'd0);
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      init      = ($urandom_range(0, 15) != 0);
      active_in = ($urandom_range(0, 15) != 0);
      Pausa_MF  = ($urandom_range(0, 3) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_data   = 6'($urandom_range(0, 63));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tx_source.md
Name: pcie_tx_source

Overview:
Transmit-side feeder for the PCIe transaction block. Buffers host-written 6-bit words in a small FIFO and drives them onto the transaction block's `data_in_principal`/`push` input. It honours the block's `Pausa_MF` back-pressure and its `active_out` state. It sits upstream of the transaction block and replaces direct probe-driven pushes in system benches.

Parameters:
DATA_W, 6, word width; matches data_in_principal.
DEPTH, 8, internal FIFO entries (power of two).
ADDR_W, 3, log2(DEPTH).

Ports:
clk  input  1  single clock, all logic on rising edge.
reset_L  input  1  asynchronous, active-low reset.
init  input  1  enable; when low the block stops pushing but keeps its FIFO contents.
active_in  input  1  transaction block's active_out; pushing is allowed only while high.
Pausa_MF  input  1  back-pressure from the transaction block's main FIFO.
wr_en  input  1  host write strobe.
wr_data  input  DATA_W  host word; bit5 = destination, bit4 = VC select, bits[3:0] = payload.
wr_full  output  1  FIFO full (combinational from occupancy).
wr_err  output  1  one-cycle pulse: write attempted while full.
data_in_principal  output  DATA_W  registered word to the transaction block.
push  output  1  registered push to the transaction block.
fifo_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
tx_count  output  8  count of words pushed; wraps 255->0.
state_out  output  2  current state encoding.

Behaviour:
- Reset (reset_L low, asynchronous) clears everything:
  - push=0, data_in_principal=0, wr_err=0, tx_count=0, fifo_count=0.
  - Pointers are zeroed and state = IDLE (encoding 00).
- States: IDLE=00, SEND=01, PAUSE=10. Encoding 11 is illegal and returns to IDLE.
- IDLE -> SEND when init=1 and active_in=1 at the clock edge.
- SEND -> PAUSE when Pausa_MF=1 at the edge.
- PAUSE -> SEND when Pausa_MF=0 at the edge.
- SEND or PAUSE -> IDLE when init=0 or active_in=0 at the edge. This exit has priority over all other transitions.
- Pop/push rule, evaluated at each edge:
  - If state==SEND, Pausa_MF==0, init==1, active_in==1 and the FIFO is non-empty, then the head word is popped.
  - At that edge push becomes 1 and data_in_principal takes the head word.
  - Otherwise push becomes 0 and data_in_principal holds its last value.
- Latency:
  - A word written into an empty FIFO at edge N is pushed at edge N+1 at the earliest. There is no bypass path.
  - Pausa_MF high at edge k gives push=0 in cycle k+1. One in-flight word may already be on the bus; the downstream threshold absorbs it.
- Write rule:
  - A write is accepted when wr_en=1 and the pre-edge count < DEPTH.
  - With wr_en=1 and a full FIFO, the word is dropped and wr_err pulses for exactly one cycle.
  - A simultaneous pop at full does not free space for the same-edge write.
- Simultaneous write and pop when not full: both occur and fifo_count is unchanged.
- Pointers wrap modulo DEPTH. fifo_count is the only full/empty reference.
- tx_count increments by 1 on every edge that asserts push and wraps modulo 256.
- Leaving SEND mid-stream (init or active_in drop): no word is lost. Remaining FIFO contents are pushed after re-entry to SEND, in original order.
- wr_full = (fifo_count == DEPTH).

Optional Feature:
Macro TX_PAUSE_CNT_EN.
- Defined:
  - Adds output pause_cycles (16 bits).
  - It increments every cycle that state==PAUSE with a non-empty FIFO, saturating at 16'hFFFF.
  - It is cleared by reset only.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. Reset, then init=1 with active_in=1, then write 6'h15 -> state_out=01. push=1 with data_in_principal=6'h15 one cycle after the write. tx_count=1.
2. Write 8 words with Pausa_MF=1 held from the start -> fifo_count=8, wr_full=1, push stays 0. A 9th write gives one wr_err pulse and fifo_count stays 8.
3. With the FIFO holding 6'h01..6'h05, pulse Pausa_MF for 3 cycles mid-stream -> push=0 for those 3 cycles, starting the cycle after the rise. Output order 01,02,03,04,05 is intact. tx_count=5.
4. Drop active_in mid-burst with 4 words left -> state_out=00 and push=0 the next cycle. Raising active_in resumes the remaining 4 words in order.
5. Push 256 words (continuous writes, no pause) -> tx_count wraps to 0. Simultaneous write and pop keep fifo_count constant at 1.
6. Assert reset_L low asynchronously mid-burst -> push, tx_count and fifo_count read 0 before the next clock edge.
